// File: rtl/sccb_write_master.sv
// SCCB/I2C write engine: START, three bytes each followed by an ACK slot, then STOP.
// SCL is push-pull, SDA is open-drain; everything is paced by a quarter-bit tick.
module sccb_write_master #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned I2C_FREQ = 100_000,
  parameter int unsigned DIV      = CLK_FREQ / (4 * I2C_FREQ)
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        phase_q, phase_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic              err_q, err_d;
  logic              scl_q, scl_d;
  logic              sda_oe_q, sda_oe_d;
  logic              end_q, end_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [1:0]        sda_sync_q;
  logic              tick;

  assign tick     = (div_q == DIV_W'(DIV - 1));
  assign I2C_SCLK = scl_q;
  assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
  assign oEND     = end_q;
  assign oACK     = ack_q;
  assign oBUSY    = busy_q;

  // SDA is driven by the slave during ACK slots, so resynchronise before sampling.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sda_sync_q <= 2'b11;
    end else begin
      sda_sync_q <= {sda_sync_q[0], I2C_SDAT};
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      err_q      <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      end_q      <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      err_q      <= err_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      end_q      <= end_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  // Each tick moves to the next phase; the case arms set the pins for the phase being entered.
  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    err_d      = err_q;
    scl_d      = scl_q;
    sda_oe_d   = sda_oe_q;
    end_d      = end_q;
    ack_d      = ack_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        if (iGO && !end_q) begin
          state_d  = S_START;
          div_d    = '0;
          phase_d  = '0;
          shift_d  = iDATA;
          err_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end

      S_START: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: sda_oe_d = 1'b1;
            2'd1: scl_d    = 1'b0;
            2'd2: ;
            2'd3: begin
              state_d    = S_BIT;
              bit_cnt_d  = 3'd7;
              byte_cnt_d = 2'd0;
              sda_oe_d   = ~shift_q[23];
            end
            default: ;
          endcase
        end
      end

      S_BIT: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: scl_d = 1'b1;
            2'd1: ;
            2'd2: begin
              scl_d   = 1'b0;
              shift_d = {shift_q[22:0], 1'b0};
            end
            2'd3: begin
              if (bit_cnt_q == 3'd0) begin
                state_d  = S_ACK;
                sda_oe_d = 1'b0;
              end else begin
                bit_cnt_d = bit_cnt_q - 3'd1;
                sda_oe_d  = ~shift_q[23];
              end
            end
            default: ;
          endcase
        end
      end

      S_ACK: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: scl_d = 1'b1;
            2'd1: ;
            2'd2: begin
              scl_d = 1'b0;
              if (sda_sync_q[1]) begin
                err_d = 1'b1;
              end
            end
            2'd3: begin
              if (byte_cnt_q == 2'd2) begin
                state_d  = S_STOP;
                sda_oe_d = 1'b1;
              end else begin
                state_d    = S_BIT;
                byte_cnt_d = byte_cnt_q + 2'd1;
                bit_cnt_d  = 3'd7;
                sda_oe_d   = ~shift_q[23];
              end
            end
            default: ;
          endcase
        end
      end

      S_STOP: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: scl_d    = 1'b1;
            2'd1: sda_oe_d = 1'b0;
            2'd2: ;
            2'd3: begin
              state_d = S_DONE;
              end_d   = 1'b1;
              ack_d   = err_q;
              busy_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end

      S_DONE: begin
        if (tick && !iGO) begin
          state_d = S_IDLE;
          end_d   = 1'b0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        busy_d   = 1'b0;
        end_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sccb_write_master.sv
// Bench for sccb_write_master: stimulus pushes expected transfers, a bus monitor with an
// ACKing slave model decodes SCL/SDA and scores transfers, completion flags and bus timing.
`timescale 1ns/1ps
module tb_sccb_write_master;

  localparam int unsigned CLK_FREQ = 400;
  localparam int unsigned I2C_FREQ = 10;
  localparam int unsigned DIV      = CLK_FREQ / (4 * I2C_FREQ);
  localparam int          TXN_CLKS = 116 * DIV;

  typedef struct packed {
    logic [23:0] data;
    logic [2:0]  nack;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [23:0] data;
  logic        oend, oack, obusy, scl;
  wire         sda;
  logic        slave_drive = 1'b0;
  logic [2:0]  slave_nack  = 3'b000;

  pullup (sda);
  assign sda = slave_drive ? 1'b0 : 1'bz;

  sccb_write_master #(
    .CLK_FREQ(CLK_FREQ),
    .I2C_FREQ(I2C_FREQ),
    .DIV     (DIV)
  ) dut (
    .iCLK    (clk),
    .iRST    (rst),
    .iDATA   (data),
    .iGO     (go),
    .oEND    (oend),
    .oACK    (oack),
    .oBUSY   (obusy),
    .I2C_SCLK(scl),
    .I2C_SDAT(sda)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Bus monitor, slave model and scoreboard consumer
  int   cyc = 0, rises = 0, last_edge = 0, busy_cyc = 0, start_cnt = 0;
  int   sl_r = 0, sl_byte = 0;
  bit   in_txn = 0, have_last = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_end = 1'b0, prev_busy = 1'b0;
  logic [26:0] bitv = '0;
  exp_t last_exp;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_txn      = 0;
      rises       = 0;
      sl_r        = 0;
      sl_byte     = 0;
      have_last   = 0;
      slave_drive = 1'b0;
    end else begin
      if (scl && prev_scl && sda !== prev_sda) begin
        if (!sda && !in_txn) begin
          in_txn    = 1;
          rises     = 0;
          bitv      = '0;
          sl_r      = 0;
          sl_byte   = 0;
          last_edge = cyc;
          start_cnt++;
        end else if (sda && in_txn && rises == 28) begin
          in_txn = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: got 0x%0h, expected no transfer", bitv);
          end else begin
            last_exp = exp_q.pop_front();
            check("bus_data", 32'({bitv[26:19], bitv[17:10], bitv[8:1]}), 32'(last_exp.data));
            check("bus_ack_bits", 32'({bitv[0], bitv[9], bitv[18]}), 32'(last_exp.nack));
            have_last = 1;
          end
        end else begin
          checks++;
          errors++;
          $display("FAIL sda_stable: got SDA %0b, expected no change while SCL high (rise %0d)",
                   sda, rises);
        end
      end
      if (in_txn && scl && !prev_scl) begin
        check_range("scl_low_time", cyc - last_edge, 2 * DIV, 100 * DIV);
        rises++;
        if (rises <= 27) bitv = {bitv[25:0], sda};
        sl_r++;
        last_edge = cyc;
      end
      if (in_txn && !scl && prev_scl) begin
        if (rises >= 1) check_range("scl_high_time", cyc - last_edge, 2 * DIV, 100 * DIV);
        last_edge = cyc;
        if (sl_r == 8 && sl_byte < 3) begin
          slave_drive = !slave_nack[sl_byte];
        end else if (sl_r == 9) begin
          slave_drive = 1'b0;
          sl_r        = 0;
          sl_byte++;
        end
      end
      if (obusy && !prev_busy) busy_cyc = cyc;
      if (oend && !prev_end) begin
        check_range("end_latency", cyc - busy_cyc, TXN_CLKS - 1, TXN_CLKS + 1);
        if (have_last) begin
          check("oack", 32'(oack), 32'(|last_exp.nack));
        end else begin
          checks++;
          errors++;
          $display("FAIL end_without_stop: got oEND=1, expected a STOP first");
        end
        check("busy_at_end", 32'(obusy), 32'd0);
        have_last = 0;
      end
    end
    prev_scl  = scl;
    prev_sda  = sda;
    prev_end  = oend;
    prev_busy = obusy;
  end

  task automatic start_txn(input logic [23:0] d, input logic [2:0] n, input bit expect_it);
    exp_t e;
    @(negedge clk);
    slave_nack = n;
    data       = d;
    go         = 1'b1;
    e.data     = d;
    e.nack     = n;
    if (expect_it) exp_q.push_back(e);
  endtask

  task automatic wait_busy();
    bit ok = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (obusy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got oBUSY=0, expected 1 after iGO");
    end
  endtask

  task automatic wait_end(output bit ok);
    ok = 0;
    for (int i = 0; i < 3 * TXN_CLKS; i++) begin
      @(negedge clk);
      if (oend) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL end_timeout: got oEND=0, expected 1 within %0d clocks", 3 * TXN_CLKS);
    end
  endtask

  task automatic drop_go();
    int n = 0;
    go = 1'b0;
    while (oend && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    check_range("end_fall_delay", n, 0, DIV);
  endtask

  task automatic run_txn(input logic [23:0] d, input logic [2:0] n);
    bit ok;
    start_txn(d, n, 1);
    wait_end(ok);
    if (ok) drop_go();
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got no finish, expected completion before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int n;
    int starts;
    rst  = 1'b1;
    go   = 1'b0;
    data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_end", 32'(oend), 32'd0);
    check("rst_ack", 32'(oack), 32'd0);
    check("rst_busy", 32'(obusy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(24'h423A04, 3'b000);
    run_txn(24'h423A04, 3'b010);
    run_txn(24'h421234, 3'b000);

    // Holding iGO after completion must not retrigger
    start_txn(24'h4255AA, 3'b000, 1);
    wait_end(ok);
    starts = start_cnt;
    repeat (500 * DIV) @(negedge clk);
    check("hold_no_restart", 32'(start_cnt), 32'(starts));
    check("hold_end_high", 32'(oend), 32'd1);
    drop_go();
    run_txn(24'h42C301, 3'b000);

    // Reset in the middle of the second byte
    start_txn(24'h425566, 3'b000, 0);
    wait_busy();
    repeat (500) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_scl", 32'(scl), 32'd1);
    check("midrst_sda", 32'(sda), 32'd1);
    check("midrst_busy", 32'(obusy), 32'd0);
    check("midrst_end", 32'(oend), 32'd0);
    repeat (3) @(negedge clk);
    begin
      exp_t e;
      e.data = 24'h425566;
      e.nack = 3'b000;
      exp_q.push_back(e);
    end
    rst = 1'b0;
    wait_end(ok);
    if (ok) drop_go();

    // Input changes after accept must not reach the bus
    start_txn(24'h421214, 3'b000, 1);
    wait_busy();
    repeat (300) @(negedge clk);
    data = 24'hFFFFFF;
    go   = 1'b0;
    wait_end(ok);
    n = 0;
    while (oend && n < 5 * DIV) begin
      @(negedge clk);
      n++;
    end
    check_range("end_pulse_len", n, DIV, 4 * DIV);
    check("idle_after_pulse", 32'({oend, obusy}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_txn(24'($urandom), 3'($urandom_range(0, 7)));
    end

    repeat (4 * DIV) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
